// File: rtl/haz_pkg.sv
// Shared types for the hazard front end: resolver state codes, scoreboard slot, counter width.
package haz_pkg;
  localparam int CNT_W     = 16;
  // Slots carry a fixed-width rd so the struct is shareable; REG_AW must not exceed this.
  localparam int SLOT_RD_W = 8;

  typedef enum logic [2:0] {
    NOR     = 3'd0,
    CON     = 3'd1,
    STA_SIN = 3'd2,
    FLUSH   = 3'd3,
    DAT     = 3'd4,
    STA_N   = 3'd5
  } res_state_e;

  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
    logic                 wr;
    logic                 is_load;
  } slot_t;

  // A source hits a slot only if it is read, the slot writes a live non-zero rd, and the names match.
  function automatic logic rd_hit(slot_t s, logic [SLOT_RD_W-1:0] rs, logic used);
    return used & s.valid & s.wr & (s.rd != '0) & (s.rd == rs);
  endfunction
endpackage

// File: rtl/haz_sat_cnt.sv
// Saturating up-counter with increment enable.
module haz_sat_cnt
  import haz_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/tt_haz_detect.sv
// Hazard request generator: shadow EX/MEM/WB scoreboard, multiplier busy counter, branch tracker.
module tt_haz_detect
  import haz_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_is_load,
  input  logic              id_is_mul,
  input  logic              id_is_branch,
  input  logic              id_pred_taken,
  input  logic              br_res_valid,
  input  logic              br_res_taken,
  input  logic              pc_freeze,
  input  logic              do_flush,
  input  logic              resolved,
  output logic              data,
  output logic              fwrd,
  output logic              str,
  output logic              ctrl,
  output logic              branch,
  output logic              crct,
  output logic              id_ready,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic              proto_err
);
  localparam int MC_W = $clog2(MUL_LAT);

  slot_t                ex, mem, wb, id_slot;
  logic [MC_W-1:0]      mul_cnt;
  logic                 br_pend, br_pred, flush_q;
  logic [SLOT_RD_W-1:0] rs1_x, rs2_x;
  logic                 hit_ex, hit_mem, hold, issue;

  assign rs1_x = SLOT_RD_W'(id_rs1);
  assign rs2_x = SLOT_RD_W'(id_rs2);

  assign id_slot.valid   = 1'b1;
  assign id_slot.rd      = SLOT_RD_W'(id_rd);
  assign id_slot.wr      = id_wr;
  assign id_slot.is_load = id_is_load;

  assign hit_ex  = rd_hit(ex,  rs1_x, id_rs1_used) | rd_hit(ex,  rs2_x, id_rs2_used);
  assign hit_mem = rd_hit(mem, rs1_x, id_rs1_used) | rd_hit(mem, rs2_x, id_rs2_used);

  // The youngest producer decides forwardability; a load still in EX has no data yet.
  assign data = id_valid & (hit_ex | hit_mem);
  assign fwrd = id_valid & (hit_ex ? ~ex.is_load : hit_mem);
  assign str  = id_valid & id_is_mul & (mul_cnt != '0);

  assign hold     = (data & ~fwrd) | str;
  assign issue    = id_valid & ~pc_freeze & ~do_flush & ~hold;
  assign id_ready = issue;

  assign branch = br_pend & br_res_valid;
  assign crct   = branch & (br_res_taken == br_pred);
  assign ctrl   = br_pend | (id_valid & id_is_branch);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex        <= '0;
      mem       <= '0;
      wb        <= '0;
      mul_cnt   <= '0;
      br_pend   <= 1'b0;
      br_pred   <= 1'b0;
      flush_q   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      wb  <= mem;
      mem <= ex;
      ex  <= issue ? id_slot : '0;

      if (issue && id_is_mul)  mul_cnt <= MC_W'(MUL_LAT - 1);
      else if (mul_cnt != '0)  mul_cnt <= mul_cnt - MC_W'(1);

      // A newly issued branch outranks the clear from an older branch resolving now.
      if (issue && id_is_branch) begin
        br_pend <= 1'b1;
        br_pred <= id_pred_taken;
      end else if (branch || do_flush) begin
        br_pend <= 1'b0;
      end

      flush_q <= do_flush;
      if (resolved && (pc_freeze || do_flush)) proto_err <= 1'b1;
    end
  end

  // WB and the MEM load flag only model retirement; nothing downstream reads them.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{wb, mem.is_load};

  haz_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_freeze | hold),
    .cnt (stall_cycles)
  );

  haz_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (do_flush & ~flush_q),
    .cnt (flush_count)
  );
endmodule

// File: tb/tb_tt_haz_detect.sv
// Directed test-plan steps followed by random traffic, checked against an issue-history model.
module tb_tt_haz_detect;
  localparam int REG_AW  = 5;
  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs1_used, id_rs2_used, id_wr, id_is_load, id_is_mul, id_is_branch, id_pred_taken;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic br_res_valid, br_res_taken, pc_freeze, do_flush, resolved;
  logic data, fwrd, str, ctrl, branch, crct, id_ready, proto_err;
  logic [15:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  tt_haz_detect #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_is_load(id_is_load), .id_is_mul(id_is_mul), .id_is_branch(id_is_branch),
    .id_pred_taken(id_pred_taken), .br_res_valid(br_res_valid), .br_res_taken(br_res_taken),
    .pc_freeze(pc_freeze), .do_flush(do_flush), .resolved(resolved), .data(data), .fwrd(fwrd),
    .str(str), .ctrl(ctrl), .branch(branch), .crct(crct), .id_ready(id_ready),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .proto_err(proto_err)
  );

  // Model: a log of issued instructions stamped with their issue cycle.
  // An instruction issued at cycle t is in EX during t+1 and MEM during t+2.
  typedef struct {int t; int rd; bit wr; bit ld;} ins_t;
  ins_t hist[$];
  int   cyc, last_mul, m_stall, m_flush;
  bit   m_pend, m_pred, m_fprev, m_perr;
  bit   e_data, e_fwrd, e_str, e_hold, e_issue, e_ctrl, e_branch, e_crct;
  int   n_chk, n_fail;

  function automatic void model_comb();
    int best = 0;
    bit bld  = 0;
    foreach (hist[i]) begin
      int age = cyc - hist[i].t;
      if (age >= 1 && age <= 2 && hist[i].wr && hist[i].rd != 0 &&
          ((id_rs1_used && int'(id_rs1) == hist[i].rd) || (id_rs2_used && int'(id_rs2) == hist[i].rd)) &&
          (best == 0 || age < best)) begin
        best = age;
        bld  = hist[i].ld;
      end
    end
    e_data   = id_valid && best != 0;
    e_fwrd   = e_data && (best == 2 || !bld);
    e_str    = id_valid && id_is_mul && (cyc - last_mul < MUL_LAT);
    e_hold   = (e_data && !e_fwrd) || e_str;
    e_issue  = id_valid && !pc_freeze && !do_flush && !e_hold;
    e_branch = m_pend && br_res_valid;
    e_crct   = e_branch && (br_res_taken == m_pred);
    e_ctrl   = m_pend || (id_valid && id_is_branch);
  endfunction

  task automatic model_seq();
    if (rst) begin
      hist.delete();
      last_mul = -1000;
      m_pend = 0; m_pred = 0; m_fprev = 0; m_perr = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      if (e_issue) begin
        hist.push_back('{cyc, int'(id_rd), id_wr, id_is_load});
        if (id_is_mul) last_mul = cyc;
      end
      if (e_issue && id_is_branch) begin
        m_pend = 1; m_pred = id_pred_taken;
      end else if (e_branch || do_flush) m_pend = 0;
      if ((pc_freeze || e_hold) && m_stall < 65535) m_stall++;
      if (do_flush && !m_fprev && m_flush < 65535) m_flush++;
      m_fprev = do_flush;
      if (resolved && (pc_freeze || do_flush)) m_perr = 1;
      while (hist.size() > 2) void'(hist.pop_front());
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input string nm, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, nm, obs, exp);
    end
  endtask

  task automatic eval(input string tag);
    #1;
    model_comb();
    chk(tag, "data",     16'(data),     16'(e_data));
    chk(tag, "fwrd",     16'(fwrd),     16'(e_fwrd));
    chk(tag, "str",      16'(str),      16'(e_str));
    chk(tag, "ctrl",     16'(ctrl),     16'(e_ctrl));
    chk(tag, "branch",   16'(branch),   16'(e_branch));
    chk(tag, "crct",     16'(crct),     16'(e_crct));
    chk(tag, "id_ready", 16'(id_ready), 16'(e_issue));
    chk(tag, "stall",    stall_cycles,  16'(m_stall));
    chk(tag, "flush",    flush_count,   16'(m_flush));
    chk(tag, "perr",     16'(proto_err), 16'(m_perr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0; id_rd = '0;
    id_wr = 0; id_is_load = 0; id_is_mul = 0; id_is_branch = 0; id_pred_taken = 0;
    br_res_valid = 0; br_res_taken = 0; pc_freeze = 0; do_flush = 0; resolved = 0;
  endtask

  task automatic instr(input int rs1, input bit u1, input int rd, input bit wr, input bit ld, input bit mul);
    idle();
    id_valid = 1; id_rs1 = REG_AW'(rs1); id_rs1_used = u1; id_rd = REG_AW'(rd);
    id_wr = wr; id_is_load = ld; id_is_mul = mul;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; last_mul = -1000;
    idle();
    rst = 1;
    @(negedge clk);
    tick(); tick();
    rst = 0;
    eval("reset");
    chk("reset", "stall_const", stall_cycles, 16'd0);

    // Load-use: one bubble, one stall cycle.
    instr(0, 0, 5, 1, 1, 0); eval("lu_load"); tick();
    instr(5, 1, 6, 1, 0, 0); eval("lu_dep0");
    chk("lu_dep0", "data_c", 16'(data), 16'd1);
    chk("lu_dep0", "fwrd_c", 16'(fwrd), 16'd0);
    chk("lu_dep0", "rdy_c",  16'(id_ready), 16'd0);
    tick();
    eval("lu_dep1");
    chk("lu_dep1", "rdy_c",   16'(id_ready), 16'd1);
    chk("lu_dep1", "stall_c", stall_cycles, 16'd1);
    tick();

    // ALU forward and r0 read.
    instr(0, 0, 3, 1, 0, 0); eval("alu_add"); tick();
    instr(3, 1, 4, 1, 0, 0); eval("alu_dep");
    chk("alu_dep", "fwrd_c", 16'(fwrd), 16'd1);
    chk("alu_dep", "rdy_c",  16'(id_ready), 16'd1);
    tick();
    instr(0, 1, 0, 1, 0, 0); eval("alu_r0");
    chk("alu_r0", "data_c", 16'(data), 16'd0);
    tick();

    // Back-to-back muls.
    instr(0, 0, 7, 1, 0, 1); eval("mul_a"); tick();
    instr(0, 0, 8, 1, 0, 1); eval("mul_b0");
    chk("mul_b0", "str_c", 16'(str), 16'd1);
    tick(); eval("mul_b1");
    chk("mul_b1", "str_c", 16'(str), 16'd1);
    tick(); eval("mul_b2");
    chk("mul_b2", "rdy_c", 16'(id_ready), 16'd1);
    tick();

    // Mispredicted branch with flush.
    idle(); id_valid = 1; id_is_branch = 1; id_pred_taken = 1; eval("br_issue"); tick();
    idle(); br_res_valid = 1; br_res_taken = 0; do_flush = 1; eval("br_res");
    chk("br_res", "ctrl_c", 16'(ctrl), 16'd1);
    chk("br_res", "branch_c", 16'(branch), 16'd1);
    chk("br_res", "crct_c", 16'(crct), 16'd0);
    tick();
    idle(); eval("br_after");
    chk("br_after", "flush_c", flush_count, 16'd1);
    chk("br_after", "ctrl_c", 16'(ctrl), 16'd0);
    tick();

    // Protocol error is sticky.
    idle(); resolved = 1; pc_freeze = 1; eval("perr_set"); tick();
    idle(); eval("perr_hold");
    chk("perr_hold", "perr_c", 16'(proto_err), 16'd1);
    tick();

    // Reset during a load-use stall.
    instr(0, 0, 9, 1, 1, 0); eval("rs_load"); tick();
    instr(9, 1, 1, 1, 0, 0); eval("rs_stall"); tick();
    idle(); rst = 1; tick(); rst = 0;
    eval("rs_after");
    chk("rs_after", "stall_c", stall_cycles, 16'd0);
    chk("rs_after", "perr_c",  16'(proto_err), 16'd0);
    tick();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      id_valid      = $urandom_range(0, 3) != 0;
      id_rs1        = REG_AW'($urandom_range(0, 3));
      id_rs2        = REG_AW'($urandom_range(0, 3));
      id_rd         = REG_AW'($urandom_range(0, 3));
      id_rs1_used   = $urandom_range(0, 3) != 0;
      id_rs2_used   = $urandom_range(0, 1) != 0;
      id_wr         = $urandom_range(0, 3) != 0;
      id_is_load    = $urandom_range(0, 3) == 0;
      id_is_mul     = $urandom_range(0, 3) == 0;
      id_is_branch  = $urandom_range(0, 4) == 0;
      id_pred_taken = $urandom_range(0, 1) != 0;
      br_res_valid  = $urandom_range(0, 3) == 0;
      br_res_taken  = $urandom_range(0, 1) != 0;
      pc_freeze     = $urandom_range(0, 7) == 0;
      do_flush      = $urandom_range(0, 9) == 0;
      resolved      = $urandom_range(0, 29) == 0;
      rst           = $urandom_range(0, 149) == 0;
      eval($sformatf("rnd%0d", i));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tt_haz_detect.md
# tt_haz_detect

Hazard-detection front end that produces the hazard request signals (`data`, `str`, `ctrl`, `branch`, `fwrd`, `crct`) consumed by the hazard-resolver FSM. It also consumes that FSM's `pc_freeze`, `do_flush` and `resolved` outputs to advance its own pipeline model. It keeps a shadow EX/MEM/WB scoreboard of destination registers, a multi-cycle-multiplier busy counter and a pending-branch tracker, and sits between the decode stage and the resolver.

## Interface
- `REG_AW`, default 5: register-address width.
- `MUL_LAT`, default 3: multiplier occupancy in cycles (≥2).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_valid` in 1: decode holds an instruction.
- `id_rs1`, `id_rs2` in REG_AW: source registers.
- `id_rs1_used`, `id_rs2_used` in 1: source is read.
- `id_rd` in REG_AW: destination register.
- `id_wr` in 1: instruction writes `id_rd`.
- `id_is_load`, `id_is_mul`, `id_is_branch` in 1: instruction class.
- `id_pred_taken` in 1: predictor guess for a branch in ID.
- `br_res_valid` in 1: EX branch-resolution pulse.
- `br_res_taken` in 1: actual branch outcome.
- `pc_freeze`, `do_flush`, `resolved` in 1: resolver outputs.
- `data`, `fwrd`, `str`, `ctrl`, `branch`, `crct` out 1: hazard requests to the resolver.
- `id_ready` out 1: decode instruction accepted this cycle.
- `stall_cycles`, `flush_count` out 16: saturating performance counters.
- `proto_err` out 1: sticky protocol error.

## Operation
- **Slots.** EX, MEM and WB each hold {valid, rd, wr, is_load}.
  - Every cycle: WB←MEM, MEM←EX.
  - EX←ID fields when `issue`, otherwise EX←bubble (valid=0).
- **Hazard flags.**
  - `hold = (data & !fwrd) | str`.
  - `issue = id_valid & !pc_freeze & !do_flush & !hold`.
  - `id_ready = issue`.
- **data.** Set when `id_valid`, a used rs equals the rd of a valid, writing EX or MEM slot, and that rd≠0.
- **fwrd.** Evaluated against the youngest matching slot:
  - EX match: 1 unless EX.is_load (load-use).
  - MEM match: 1.
  - `fwrd`=0 when `data`=0.
- **str.** `id_valid & id_is_mul & (mul_cnt≠0)`.
  - `mul_cnt` loads MUL_LAT−1 when a mul issues.
  - Otherwise it decrements toward 0.
- **Branch tracker.** Holds `br_pend` and `br_pred`.
  - An issued branch sets `br_pend` and `br_pred←id_pred_taken`.
  - `ctrl = br_pend | (id_valid & id_is_branch)`.
  - `branch = br_pend & br_res_valid`.
  - `crct = branch & (br_res_taken == br_pred)`.
  - `br_pend` clears on `branch` or `do_flush`.
- **Flush.** `do_flush` forces the EX bubble, blocks issue and clears `br_pend`. MEM and WB keep shifting, since older instructions complete.
- **Counters.**
  - `stall_cycles` +1 each cycle with `pc_freeze|hold`.
  - `flush_count` +1 on each rising edge of `do_flush`.
  - Both saturate at 0xFFFF.
- **proto_err.** Set when `resolved & (pc_freeze|do_flush)`. Cleared only by `rst`.

## Timing
- Hazard outputs, `id_ready` and `issue` are combinational from the ID inputs and the registered state, in the same cycle. The resolver registers them one cycle later.
- `hold` is a local interlock. It covers the cycle before the resolver's `pc_freeze` rises, so no load-use or busy-mul instruction issues early.
- Reset: all slots invalid, `mul_cnt`=0, `br_pend`=0, counters 0, `proto_err`=0. With `id_valid`=0, every output is 0.
- Load-use: the dependent instruction issues 2 cycles after the load issued (one bubble).
- Simultaneous `do_flush` and `br_res_valid`: `branch`/`crct` are still reported that cycle, and `br_pend` clears.
- Simultaneous mul issue and `mul_cnt` decrement: the load wins.
- A branch issued in the same cycle as an older resolution sets `br_pend` for the new branch.
- `rst` mid-operation discards all in-flight state at the next edge.

## Structure
- Shared package `haz_pkg`:
  - resolver state encodings Nor=0, Con=1, StaSin=2, Flush=3, Dat=4, StaN=5;
  - scoreboard slot struct {valid, rd, wr, is_load};
  - counter width 16.
- One natural sub-module, `haz_sat_cnt` (16-bit saturating counter with increment enable), instantiated twice.

## Test plan
- **Load-use.** Load r5 issues, next ID reads r5 → `data`=1, `fwrd`=0, `id_ready`=0. One bubble, then issue, with `stall_cycles`=1.
- **ALU forward.** Add r3 issues, next ID reads r3 → `data`=1, `fwrd`=1, `id_ready`=1, no stall. A read of r0 → `data`=0.
- **Multiplier busy.** MUL_LAT=3, back-to-back muls → `str`=1 for 2 cycles, second mul issues on the 3rd cycle.
- **Branch mispredict.** Branch with pred=1 issues, then `br_res_valid`=1 with taken=0 → `ctrl`=1, `branch`=1, `crct`=0. With `do_flush` driven: EX bubble, `br_pend`=0, `flush_count`=1.
- **Protocol error and reset.** Drive `resolved`=1 with `pc_freeze`=1 → `proto_err`=1 sticky. Assert `rst` mid-stall → all outputs 0 next cycle.
